// File: rtl/ps2_keyboard_ctrl_pkg.sv
// Shared constants and state encoding for the PS/2 keyboard controller.
package ps2_keyboard_ctrl_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_DATA   = 2'd1,
        ST_PARITY = 2'd2,
        ST_STOP   = 2'd3
    } frame_state_e;

    localparam logic [7:0] SC_EXT    = 8'hE0;
    localparam logic [7:0] SC_BREAK  = 8'hF0;
    localparam logic [7:0] SC_LSHIFT = 8'h12;
    localparam logic [7:0] SC_RSHIFT = 8'h59;

    localparam logic [7:0] ASCII_LF    = 8'h0A;
    localparam logic [7:0] ASCII_BS    = 8'h08;
    localparam logic [7:0] ASCII_SPACE = 8'h20;

endpackage

// File: rtl/ps2_scancode_to_ascii.sv
// Combinational set-2 make code to ASCII lookup; letters honour shift.
module ps2_scancode_to_ascii
    import ps2_keyboard_ctrl_pkg::*;
(
    input  logic [7:0] code_i,
    input  logic       shift_i,
    output logic [7:0] ascii_o,
    output logic       mapped_o
);

    logic [7:0] base;
    logic       letter;

    always_comb begin
        base     = 8'h00;
        letter   = 1'b1;
        mapped_o = 1'b1;
        case (code_i)
            8'h1C: base = 8'h61;  8'h32: base = 8'h62;  8'h21: base = 8'h63;
            8'h23: base = 8'h64;  8'h24: base = 8'h65;  8'h2B: base = 8'h66;
            8'h34: base = 8'h67;  8'h33: base = 8'h68;  8'h43: base = 8'h69;
            8'h3B: base = 8'h6A;  8'h42: base = 8'h6B;  8'h4B: base = 8'h6C;
            8'h3A: base = 8'h6D;  8'h31: base = 8'h6E;  8'h44: base = 8'h6F;
            8'h4D: base = 8'h70;  8'h15: base = 8'h71;  8'h2D: base = 8'h72;
            8'h1B: base = 8'h73;  8'h2C: base = 8'h74;  8'h3C: base = 8'h75;
            8'h2A: base = 8'h76;  8'h1D: base = 8'h77;  8'h22: base = 8'h78;
            8'h35: base = 8'h79;  8'h1A: base = 8'h7A;
            default: begin
                letter = 1'b0;
                case (code_i)
                    8'h45: base = 8'h30;  8'h16: base = 8'h31;  8'h1E: base = 8'h32;
                    8'h26: base = 8'h33;  8'h25: base = 8'h34;  8'h2E: base = 8'h35;
                    8'h36: base = 8'h36;  8'h3D: base = 8'h37;  8'h3E: base = 8'h38;
                    8'h46: base = 8'h39;
                    8'h29: base = ASCII_SPACE;
                    8'h5A: base = ASCII_LF;
                    8'h66: base = ASCII_BS;
                    default: mapped_o = 1'b0;
                endcase
            end
        endcase
        ascii_o = (letter && shift_i) ? base - 8'h20 : base;
    end

endmodule

// File: rtl/ps2_keyboard_ctrl.sv
// PS/2 receiver: filtered clock, frame FSM, set-2 decode and ASCII FIFO.
//   state     | meaning
//   ST_IDLE   | waiting for a start bit on the next falling edge
//   ST_DATA   | shifting in 8 data bits, LSB first
//   ST_PARITY | capturing the odd-parity bit
//   ST_STOP   | checking stop bit and parity, then emitting the scancode
module ps2_keyboard_ctrl
    import ps2_keyboard_ctrl_pkg::*;
#(
    parameter int FIFO_DEPTH     = 4,
    parameter int FILTER_LEN     = 8,
    parameter int TIMEOUT_CYCLES = 50000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       ps2_clk_i,
    input  logic       ps2_data_i,
    input  logic       kb_data_receive_i,
    output logic       kb_data_ready_o,
    output logic [7:0] kb_ascii_o,
    output logic       kb_overflow_o,
    output logic       kb_frame_err_o
);

    localparam int PW = $clog2(FIFO_DEPTH);
    localparam int CW = $clog2(FIFO_DEPTH + 1);
    localparam int FW = $clog2(FILTER_LEN + 1);
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

    logic [1:0]    clk_sync_q, data_sync_q;
    logic          filt_q, filt_d;
    logic [FW-1:0] filt_cnt_q, filt_cnt_d;
    logic          fall, data_s;

    frame_state_e  state_q, state_d;
    logic [2:0]    bit_cnt_q, bit_cnt_d;
    logic [7:0]    sh_q, sh_d;
    logic          par_q, par_d;
    logic [TW-1:0] tmo_q, tmo_d;
    logic          err_q, err_d;
    logic          sc_stb_q, sc_stb_d;

    logic          brk_q, brk_d, ext_q, ext_d, shift_q, shift_d;
    logic          push;
    logic [7:0]    map_ascii;
    logic          map_hit;

    logic [7:0]    mem_q [FIFO_DEPTH];
    logic [PW-1:0] wr_ptr_q, rd_ptr_q;
    logic [CW-1:0] count_q;
    logic          rx_prev_q, ovf_q;
    logic          empty, full, pop, do_push;

    assign data_s = data_sync_q[1];

    // The filtered level flips only after FILTER_LEN consecutive differing samples.
    always_comb begin
        filt_d     = filt_q;
        filt_cnt_d = '0;
        if (clk_sync_q[1] != filt_q) begin
            if (filt_cnt_q == FW'(FILTER_LEN - 1)) filt_d = clk_sync_q[1];
            else                                   filt_cnt_d = filt_cnt_q + 1'b1;
        end
    end

    assign fall = filt_q & ~filt_d;

    always_comb begin
        state_d   = state_q;
        bit_cnt_d = bit_cnt_q;
        sh_d      = sh_q;
        par_d     = par_q;
        tmo_d     = tmo_q;
        err_d     = 1'b0;
        sc_stb_d  = 1'b0;
        if (fall) begin
            tmo_d = TW'(TIMEOUT_CYCLES - 1);
            case (state_q)
                ST_IDLE: begin
                    if (!data_s) begin
                        state_d   = ST_DATA;
                        bit_cnt_d = '0;
                    end else begin
                        err_d = 1'b1;
                    end
                end
                ST_DATA: begin
                    sh_d      = {data_s, sh_q[7:1]};
                    bit_cnt_d = bit_cnt_q + 1'b1;
                    if (bit_cnt_q == 3'd7) state_d = ST_PARITY;
                end
                ST_PARITY: begin
                    par_d   = data_s;
                    state_d = ST_STOP;
                end
                ST_STOP: begin
                    if (data_s && (^{sh_q, par_q})) sc_stb_d = 1'b1;
                    else                            err_d    = 1'b1;
                    state_d = ST_IDLE;
                end
                default: state_d = ST_IDLE;
            endcase
        end else if (state_q != ST_IDLE) begin
            if (tmo_q == '0) begin
                state_d = ST_IDLE;
                err_d   = 1'b1;
            end else begin
                tmo_d = tmo_q - 1'b1;
            end
        end
    end

    ps2_scancode_to_ascii u_map (
        .code_i   (sh_q),
        .shift_i  (shift_q),
        .ascii_o  (map_ascii),
        .mapped_o (map_hit)
    );

    always_comb begin
        brk_d   = brk_q;
        ext_d   = ext_q;
        shift_d = shift_q;
        push    = 1'b0;
        if (sc_stb_q) begin
            brk_d = 1'b0;
            ext_d = 1'b0;
            case (sh_q)
                SC_EXT:              begin ext_d = 1'b1; brk_d = brk_q; end
                SC_BREAK:            begin brk_d = 1'b1; ext_d = ext_q; end
                SC_LSHIFT, SC_RSHIFT: shift_d = ~brk_q;
                default:             push = ~brk_q & ~ext_q & map_hit;
            endcase
        end
    end

    assign empty   = (count_q == '0);
    assign full    = (count_q == CW'(FIFO_DEPTH));
    // Pop on the rising edge of the strobe so the head is stable for the whole read.
    assign pop     = ~rx_prev_q & kb_data_receive_i & ~empty;
    assign do_push = push & (~full | pop);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            clk_sync_q  <= 2'b11;
            data_sync_q <= 2'b11;
            filt_q      <= 1'b1;
            filt_cnt_q  <= '0;
            state_q     <= ST_IDLE;
            bit_cnt_q   <= '0;
            sh_q        <= '0;
            par_q       <= 1'b0;
            tmo_q       <= '0;
            err_q       <= 1'b0;
            sc_stb_q    <= 1'b0;
            brk_q       <= 1'b0;
            ext_q       <= 1'b0;
            shift_q     <= 1'b0;
            for (int i = 0; i < FIFO_DEPTH; i++) mem_q[i] <= '0;
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
            rx_prev_q   <= 1'b1;
            ovf_q       <= 1'b0;
        end else begin
            clk_sync_q  <= {clk_sync_q[0], ps2_clk_i};
            data_sync_q <= {data_sync_q[0], ps2_data_i};
            filt_q      <= filt_d;
            filt_cnt_q  <= filt_cnt_d;
            state_q     <= state_d;
            bit_cnt_q   <= bit_cnt_d;
            sh_q        <= sh_d;
            par_q       <= par_d;
            tmo_q       <= tmo_d;
            err_q       <= err_d;
            sc_stb_q    <= sc_stb_d;
            brk_q       <= brk_d;
            ext_q       <= ext_d;
            shift_q     <= shift_d;
            rx_prev_q   <= kb_data_receive_i;
            ovf_q       <= push & full & ~pop;
            if (do_push) begin
                mem_q[wr_ptr_q] <= map_ascii;
                wr_ptr_q        <= wr_ptr_q + 1'b1;
            end
            if (pop) rd_ptr_q <= rd_ptr_q + 1'b1;
            if (do_push && !pop)      count_q <= count_q + 1'b1;
            else if (pop && !do_push) count_q <= count_q - 1'b1;
        end
    end

    assign kb_data_ready_o = ~empty;
    assign kb_ascii_o      = empty ? 8'h00 : mem_q[rd_ptr_q];
    assign kb_overflow_o   = ovf_q;
    assign kb_frame_err_o  = err_q;

endmodule

// File: tb/tb_ps2_keyboard_ctrl.sv
// Directed bench: PS/2 frames in, ASCII FIFO contents and pulses checked.
module tb_ps2_keyboard_ctrl;
    import ps2_keyboard_ctrl_pkg::*;

    localparam int HALF = 20;
    localparam int TMO  = 400;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       ps2_clk_i = 1'b1;
    logic       ps2_data_i = 1'b1;
    logic       kb_data_receive_i = 1'b1;
    logic       kb_data_ready_o;
    logic [7:0] kb_ascii_o;
    logic       kb_overflow_o;
    logic       kb_frame_err_o;

    int checks = 0;
    int failures = 0;
    int err_cnt = 0;
    int ovf_cnt = 0;
    int lat = 0;
    int e0;

    ps2_keyboard_ctrl #(
        .FIFO_DEPTH     (4),
        .FILTER_LEN     (8),
        .TIMEOUT_CYCLES (TMO)
    ) dut (
        .clk               (clk),
        .rst               (rst),
        .ps2_clk_i         (ps2_clk_i),
        .ps2_data_i        (ps2_data_i),
        .kb_data_receive_i (kb_data_receive_i),
        .kb_data_ready_o   (kb_data_ready_o),
        .kb_ascii_o        (kb_ascii_o),
        .kb_overflow_o     (kb_overflow_o),
        .kb_frame_err_o    (kb_frame_err_o)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (kb_frame_err_o === 1'b1) err_cnt++;
        if (kb_overflow_o === 1'b1)  ovf_cnt++;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Frame: start, 8 data LSB first, odd parity (optionally corrupted), stop.
    task automatic send_frame(input logic [7:0] b, input logic flip, input int nbits);
        logic [10:0] f;
        f = {1'b1, (~^b) ^ flip, b, 1'b0};
        for (int i = 0; i < nbits; i++) begin
            ps2_data_i = f[i];
            repeat (HALF) @(negedge clk);
            ps2_clk_i = 1'b0;
            for (int k = 1; k <= HALF; k++) begin
                @(negedge clk);
                if (i == 10 && kb_data_ready_o === 1'b1 && lat == 0) lat = k;
            end
            ps2_clk_i = 1'b1;
        end
        ps2_data_i = 1'b1;
        repeat (HALF) @(negedge clk);
    endtask

    task automatic pop_one();
        kb_data_receive_i = 1'b0;
        repeat (3) @(negedge clk);
        kb_data_receive_i = 1'b1;
        repeat (2) @(negedge clk);
    endtask

    initial begin
        repeat (4) @(negedge clk);
        check("rst_ready", 32'(kb_data_ready_o), 'h0);
        check("rst_ascii", 32'(kb_ascii_o), 'h00);
        check("rst_ovf",   32'(kb_overflow_o), 'h0);
        check("rst_err",   32'(kb_frame_err_o), 'h0);
        rst = 1'b1;
        repeat (4) @(negedge clk);

        // 2 sync + 8 filter samples put the fall strobe after edge 9; ready follows at edge 11.
        lat = 0;
        send_frame(8'h1C, 1'b0, 11);
        check("a_latency", 32'(lat), 11);
        check("a_ready", 32'(kb_data_ready_o), 'h1);
        check("a_ascii", 32'(kb_ascii_o), 'h61);
        check("a_no_err", 32'(err_cnt), 0);
        kb_data_receive_i = 1'b0;
        repeat (3) @(negedge clk);
        check("a_hold_during_read", 32'(kb_ascii_o), 'h61);
        kb_data_receive_i = 1'b1;
        repeat (2) @(negedge clk);
        check("a_popped_ready", 32'(kb_data_ready_o), 'h0);
        check("a_popped_ascii", 32'(kb_ascii_o), 'h00);
        pop_one();
        check("empty_pop_ignored", 32'(kb_data_ready_o), 'h0);

        send_frame(8'h1C, 1'b0, 11);
        send_frame(8'hF0, 1'b0, 11);
        send_frame(8'h1C, 1'b0, 11);
        check("brk_head", 32'(kb_ascii_o), 'h61);
        pop_one();
        check("brk_one_entry", 32'(kb_data_ready_o), 'h0);

        send_frame(8'h12, 1'b0, 11);
        send_frame(8'h1C, 1'b0, 11);
        send_frame(8'hF0, 1'b0, 11);
        send_frame(8'h12, 1'b0, 11);
        send_frame(8'h1C, 1'b0, 11);
        check("shift_upper", 32'(kb_ascii_o), 'h41);
        pop_one();
        check("shift_released", 32'(kb_ascii_o), 'h61);
        pop_one();
        check("shift_empty", 32'(kb_data_ready_o), 'h0);

        send_frame(8'h59, 1'b0, 11);
        send_frame(8'h16, 1'b0, 11);
        send_frame(8'h5A, 1'b0, 11);
        send_frame(8'hF0, 1'b0, 11);
        send_frame(8'h59, 1'b0, 11);
        send_frame(8'h66, 1'b0, 11);
        check("digit_ignores_shift", 32'(kb_ascii_o), 'h31);
        pop_one();
        check("enter", 32'(kb_ascii_o), 'h0A);
        pop_one();
        check("backspace", 32'(kb_ascii_o), 'h08);
        pop_one();

        send_frame(8'hE0, 1'b0, 11);
        send_frame(8'h1C, 1'b0, 11);
        send_frame(8'hE0, 1'b0, 11);
        send_frame(8'hF0, 1'b0, 11);
        send_frame(8'h1C, 1'b0, 11);
        send_frame(8'h05, 1'b0, 11);
        check("ext_unmapped_none", 32'(kb_data_ready_o), 'h0);

        e0 = err_cnt;
        send_frame(8'h1C, 1'b1, 11);
        check("parity_err", 32'(err_cnt), 32'(e0 + 1));
        check("parity_no_data", 32'(kb_data_ready_o), 'h0);

        send_frame(8'h1C, 1'b0, 11);
        send_frame(8'h32, 1'b0, 11);
        send_frame(8'h21, 1'b0, 11);
        send_frame(8'h23, 1'b0, 11);
        check("full_no_ovf", 32'(ovf_cnt), 0);
        send_frame(8'h24, 1'b0, 11);
        check("ovf_pulse", 32'(ovf_cnt), 1);
        check("ovf_head_a", 32'(kb_ascii_o), 'h61);
        pop_one();
        check("ovf_head_b", 32'(kb_ascii_o), 'h62);
        pop_one();
        check("ovf_head_c", 32'(kb_ascii_o), 'h63);
        pop_one();
        check("ovf_head_d", 32'(kb_ascii_o), 'h64);
        pop_one();
        check("ovf_drained", 32'(kb_data_ready_o), 'h0);

        e0 = err_cnt;
        send_frame(8'h1C, 1'b0, 5);
        repeat (300) @(negedge clk);
        check("tmo_not_yet", 32'(err_cnt), 32'(e0));
        repeat (150) @(negedge clk);
        check("tmo_err", 32'(err_cnt), 32'(e0 + 1));
        check("tmo_idle", 32'(dut.state_q), 32'(ST_IDLE));
        send_frame(8'h29, 1'b0, 11);
        check("tmo_space", 32'(kb_ascii_o), 'h20);
        pop_one();

        send_frame(8'h1C, 1'b0, 11);
        send_frame(8'h32, 1'b0, 11);
        send_frame(8'h4D, 1'b0, 3);
        rst = 1'b0;
        repeat (3) @(negedge clk);
        check("midrst_ready", 32'(kb_data_ready_o), 'h0);
        check("midrst_ascii", 32'(kb_ascii_o), 'h00);
        rst = 1'b1;
        repeat (4) @(negedge clk);
        send_frame(8'h4D, 1'b0, 11);
        check("postrst_ready", 32'(kb_data_ready_o), 'h1);
        check("postrst_ascii", 32'(kb_ascii_o), 'h70);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
